// File: rtl/instr_issue.sv
// Fetch/issue front end: PC, synchronous imem fetch, 2-entry issue queue, redirect and halt.
// Optional ISSUE_PERF_EN adds saturating issued/stall counters (perf_issued, perf_stall).
module instr_issue #(
    parameter int          AW      = 10,
    parameter int          DW      = 32,
    parameter logic [5:0]  HALT_OP = 6'b111111
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          imem_rd_en,
    output logic [AW-1:0] imem_addr,
    input  logic [DW-1:0] imem_rdata,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [DW-1:0] instr,
    output logic [5:0]    opcode,
    output logic [AW-1:0] instr_pc,
`ifdef ISSUE_PERF_EN
    output logic [15:0]   perf_issued,
    output logic [15:0]   perf_stall,
`endif
    output logic          halted
);

    logic [AW-1:0] pc_q, pc_d;
    logic          inflight_q;
    logic [AW-1:0] inflight_pc_q;
    logic          halt_pending_q, halt_pending_d;
    logic          halted_q;
    logic [1:0]    count_q, count_d;
    logic [DW-1:0] head_instr_q, head_instr_d, tail_instr_q, tail_instr_d;
    logic [AW-1:0] head_pc_q, head_pc_d, tail_pc_q, tail_pc_d;

    logic       pop, push, flush, halt_accept, fetch_room;
    logic [2:0] occ;

    assign instr_valid = (count_q != 2'd0);
    assign pop         = instr_valid & instr_ready;
    assign halt_accept = pop & (head_instr_q[DW-1 -: 6] == HALT_OP) & ~halted_q;
    // A halt leaving the queue takes priority over a redirect in the same cycle
    assign flush       = redirect_valid & ~halted_q & ~halt_accept;
    assign push        = inflight_q & ~flush & ~halt_pending_q & ~halted_q;

    assign occ        = {1'b0, count_q} + {2'b00, inflight_q};
    assign fetch_room = occ < (3'd2 + {2'b00, pop});
    assign imem_rd_en = rst_n & ~redirect_valid & ~halted_q & ~halt_pending_q & fetch_room;
    assign imem_addr  = pc_q;

    assign instr    = head_instr_q;
    assign opcode   = head_instr_q[DW-1 -: 6];
    assign instr_pc = head_pc_q;
    assign halted   = halted_q;

    always_comb begin
        pc_d = pc_q;
        if (flush)
            pc_d = redirect_pc;
        else if (imem_rd_en)
            pc_d = pc_q + 1'b1;
    end

    always_comb begin
        halt_pending_d = halt_pending_q;
        if (flush)
            halt_pending_d = 1'b0;
        else if (push && imem_rdata[DW-1 -: 6] == HALT_OP)
            halt_pending_d = 1'b1;
    end

    // Head registers are only overwritten by real data so they hold when the queue drains
    always_comb begin
        count_d      = count_q;
        head_instr_d = head_instr_q;
        head_pc_d    = head_pc_q;
        tail_instr_d = tail_instr_q;
        tail_pc_d    = tail_pc_q;
        if (flush) begin
            count_d = 2'd0;
        end else if (pop && push) begin
            if (count_q == 2'd2) begin
                head_instr_d = tail_instr_q;
                head_pc_d    = tail_pc_q;
                tail_instr_d = imem_rdata;
                tail_pc_d    = inflight_pc_q;
            end else begin
                head_instr_d = imem_rdata;
                head_pc_d    = inflight_pc_q;
            end
        end else if (pop) begin
            if (count_q == 2'd2) begin
                head_instr_d = tail_instr_q;
                head_pc_d    = tail_pc_q;
            end
            count_d = count_q - 2'd1;
        end else if (push) begin
            if (count_q == 2'd0) begin
                head_instr_d = imem_rdata;
                head_pc_d    = inflight_pc_q;
            end else begin
                tail_instr_d = imem_rdata;
                tail_pc_d    = inflight_pc_q;
            end
            count_d = count_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q           <= '0;
            inflight_q     <= 1'b0;
            inflight_pc_q  <= '0;
            halt_pending_q <= 1'b0;
            halted_q       <= 1'b0;
            count_q        <= 2'd0;
            head_instr_q   <= '0;
            head_pc_q      <= '0;
            tail_instr_q   <= '0;
            tail_pc_q      <= '0;
        end else begin
            pc_q           <= pc_d;
            inflight_q     <= imem_rd_en;
            inflight_pc_q  <= pc_q;
            halt_pending_q <= halt_pending_d;
            halted_q       <= halted_q | halt_accept;
            count_q        <= count_d;
            head_instr_q   <= head_instr_d;
            head_pc_q      <= head_pc_d;
            tail_instr_q   <= tail_instr_d;
            tail_pc_q      <= tail_pc_d;
        end
    end

`ifdef ISSUE_PERF_EN
    logic [15:0] perf_issued_q, perf_stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued_q <= 16'h0000;
            perf_stall_q  <= 16'h0000;
        end else begin
            if (pop && perf_issued_q != 16'hFFFF)
                perf_issued_q <= perf_issued_q + 16'h0001;
            if (instr_valid && !instr_ready && perf_stall_q != 16'hFFFF)
                perf_stall_q <= perf_stall_q + 16'h0001;
        end
    end

    assign perf_issued = perf_issued_q;
    assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_instr_issue.sv
// Directed bench for instr_issue: streaming, backpressure, redirect, halt, PC wrap, async reset.
module tb_instr_issue;

    localparam logic [5:0] HALT = 6'b111111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_rd_en;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [9:0]  redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [9:0]  instr_pc;
    logic        halted;
`ifdef ISSUE_PERF_EN
    logic [15:0] perf_issued, perf_stall;
    logic [15:0] s_perf_issued, s_perf_stall;
`endif

    logic        s_rd_en;
    logic [3:0]  s_addr;
    logic [31:0] s_rdata = '0;
    logic        s_redirect = 1'b0;
    logic [3:0]  s_redirect_pc = '0;
    logic        s_valid;
    logic [31:0] s_instr;
    logic [5:0]  s_opcode;
    logic [3:0]  s_instr_pc;
    logic        s_halted;

    logic [31:0] mem   [1024];
    logic [31:0] s_mem [16];

    int checks = 0;
    int errors = 0;
    int nfetch = 0;
    logic [9:0] last_addr = '0;
    logic [31:0] saved;

    always #5 clk = ~clk;

    instr_issue #(.AW(10), .DW(32), .HALT_OP(HALT)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .imem_rd_en(imem_rd_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .opcode(opcode), .instr_pc(instr_pc),
`ifdef ISSUE_PERF_EN
        .perf_issued(perf_issued), .perf_stall(perf_stall),
`endif
        .halted(halted)
    );

    instr_issue #(.AW(4), .DW(32), .HALT_OP(HALT)) u_small (
        .clk(clk), .rst_n(rst_n),
        .imem_rd_en(s_rd_en), .imem_addr(s_addr), .imem_rdata(s_rdata),
        .redirect_valid(s_redirect), .redirect_pc(s_redirect_pc),
        .instr_valid(s_valid), .instr_ready(1'b1),
        .instr(s_instr), .opcode(s_opcode), .instr_pc(s_instr_pc),
`ifdef ISSUE_PERF_EN
        .perf_issued(s_perf_issued), .perf_stall(s_perf_stall),
`endif
        .halted(s_halted)
    );

    // Synchronous instruction memories with one-cycle read latency
    always @(posedge clk) begin
        if (imem_rd_en) imem_rdata <= mem[imem_addr];
        if (s_rd_en)    s_rdata    <= s_mem[s_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Record any fetch of the current cycle, then advance to just after the next edge
    task automatic tick();
        #1;
        if (imem_rd_en === 1'b1) begin
            nfetch++;
            last_addr = imem_addr;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic ready);
        rst_n = 1'b0;
        instr_ready = ready;
        redirect_valid = 1'b0;
        s_redirect = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        nfetch = 0;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = {6'((i % 62) + 1), 26'(i)};
        for (int i = 0; i < 16; i++) s_mem[i] = {6'(i + 1), 26'(i + 32'h100)};
        mem[0] = 32'h0400_0000;
        mem[1] = 32'h0800_0000;
        mem[2] = 32'h0C00_0000;
        mem[3] = 32'h1000_0000;

        // Reset values while held in reset
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_rd_en", 64'(imem_rd_en), 0);
        chk("rst_addr", 64'(imem_addr), 0);
        chk("rst_valid", 64'(instr_valid), 0);
        chk("rst_instr", 64'(instr), 0);
        chk("rst_opcode", 64'(opcode), 0);
        chk("rst_pc", 64'(instr_pc), 0);
        chk("rst_halted", 64'(halted), 0);

        // Streaming with ready held high
        rst_n = 1'b1;
        #1;
        chk("a_c0_rd_en", 64'(imem_rd_en), 1);
        chk("a_c0_addr", 64'(imem_addr), 0);
        chk("a_c0_valid", 64'(instr_valid), 0);
        tick();
        chk("a_c1_addr", 64'(imem_addr), 1);
        chk("a_c1_valid", 64'(instr_valid), 0);
        tick();
        chk("a_c2_addr", 64'(imem_addr), 2);
        chk("a_c2_valid", 64'(instr_valid), 1);
        chk("a_c2_op", 64'(opcode), 64'(6'b000001));
        chk("a_c2_pc", 64'(instr_pc), 0);
        tick();
        chk("a_c3_addr", 64'(imem_addr), 3);
        chk("a_c3_op", 64'(opcode), 64'(6'b000010));
        tick();
        chk("a_c4_op", 64'(opcode), 64'(6'b000011));
        tick();
        chk("a_c5_op", 64'(opcode), 64'(6'b000100));
        chk("a_c5_instr", 64'(instr), 64'h1000_0000);

        // Backpressure: ready low for five cycles from first valid
        do_reset(1'b0);
        tick();
        tick();
        for (int c = 2; c <= 6; c++) begin
            chk("b_stall_valid", 64'(instr_valid), 1);
            chk("b_stall_pc", 64'(instr_pc), 0);
            chk("b_stall_op", 64'(opcode), 64'(6'b000001));
            tick();
        end
        chk("b_fetches", 64'(nfetch), 2);
`ifdef ISSUE_PERF_EN
        chk("b_perf_stall", 64'(perf_stall), 5);
        chk("b_perf_issued", 64'(perf_issued), 0);
`endif
        instr_ready = 1'b1;
        #1;
        chk("b_rel0_pc", 64'(instr_pc), 0);
        chk("b_rel0_addr", 64'(imem_addr), 2);
        tick();
        chk("b_rel1_pc", 64'(instr_pc), 1);
        chk("b_rel1_valid", 64'(instr_valid), 1);
        tick();
        chk("b_rel2_pc", 64'(instr_pc), 2);
        chk("b_rel2_instr", 64'(instr), 64'h0C00_0000);

        // Redirect while a fetch is in flight
        do_reset(1'b1);
        tick();
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 10'h050;
        #1;
        chk("c_T_rd_en", 64'(imem_rd_en), 0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("c_T1_rd_en", 64'(imem_rd_en), 1);
        chk("c_T1_addr", 64'(imem_addr), 64'h050);
        chk("c_T1_valid", 64'(instr_valid), 0);
        tick();
        chk("c_T2_valid", 64'(instr_valid), 0);
        chk("c_T2_addr", 64'(imem_addr), 64'h051);
        tick();
        chk("c_T3_valid", 64'(instr_valid), 1);
        chk("c_T3_pc", 64'(instr_pc), 64'h050);
        chk("c_T3_instr", 64'(instr), 64'(mem[10'h050]));
        tick();
        chk("c_T4_pc", 64'(instr_pc), 64'h051);

        // Halt opcode at address 5
        mem[5] = {HALT, 26'h5};
        mem[6] = 32'hDEAD_BEEF;
        mem[7] = 32'h1234_5678;
        do_reset(1'b1);
        repeat (7) tick();
        chk("d_head_pc", 64'(instr_pc), 5);
        chk("d_head_op", 64'(opcode), 64'(HALT));
        chk("d_pre_halted", 64'(halted), 0);
        tick();
        chk("d_halted", 64'(halted), 1);
        chk("d_valid_after", 64'(instr_valid), 0);
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 10'h020;
        #1;
        chk("d_redir_rd_en", 64'(imem_rd_en), 0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("d_post_rd_en", 64'(imem_rd_en), 0);
        chk("d_post_halted", 64'(halted), 1);
        tick();
        chk("d_fetch_count", 64'(nfetch), 7);
        chk("d_last_addr", 64'(last_addr), 6);

        // Halt at address 3 cancelled by redirect before it is accepted
        mem[5] = {6'(5 + 1), 26'(5)};
        saved = mem[3];
        mem[3] = {HALT, 26'h3};
        do_reset(1'b1);
        repeat (5) tick();
        chk("e_head_pc", 64'(instr_pc), 3);
        chk("e_head_op", 64'(opcode), 64'(HALT));
        chk("e_pending_rd_en", 64'(imem_rd_en), 0);
        instr_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 10'h100;
        tick();
        redirect_valid = 1'b0;
        instr_ready = 1'b1;
        #1;
        chk("e_T1_rd_en", 64'(imem_rd_en), 1);
        chk("e_T1_addr", 64'(imem_addr), 64'h100);
        chk("e_T1_halted", 64'(halted), 0);
        tick();
        tick();
        chk("e_T3_valid", 64'(instr_valid), 1);
        chk("e_T3_pc", 64'(instr_pc), 64'h100);
        chk("e_T3_instr", 64'(instr), 64'(mem[10'h100]));
        tick();
        chk("e_T4_pc", 64'(instr_pc), 64'h101);
        chk("e_T4_halted", 64'(halted), 0);
        mem[3] = saved;

        // PC wrap on the AW=4 instance
        do_reset(1'b1);
        s_redirect = 1'b1;
        s_redirect_pc = 4'hF;
        #1;
        chk("f_T_rd_en", 64'(s_rd_en), 0);
        tick();
        s_redirect = 1'b0;
        #1;
        chk("f_T1_rd_en", 64'(s_rd_en), 1);
        chk("f_T1_addr", 64'(s_addr), 64'hF);
        tick();
        chk("f_T2_addr", 64'(s_addr), 0);
        tick();
        chk("f_T3_addr", 64'(s_addr), 1);
        chk("f_T3_valid", 64'(s_valid), 1);
        chk("f_T3_pc", 64'(s_instr_pc), 64'hF);
        chk("f_T3_instr", 64'(s_instr), 64'(s_mem[15]));
        chk("f_T3_op", 64'(s_opcode), 64'(6'd16));
        tick();
        chk("f_T4_pc", 64'(s_instr_pc), 0);
        chk("f_halted", 64'(s_halted), 0);

        // Asynchronous reset mid-stream with the queue full
        do_reset(1'b0);
        repeat (3) tick();
        chk("g_full_valid", 64'(instr_valid), 1);
        chk("g_full_addr", 64'(imem_addr), 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("g_rst_valid", 64'(instr_valid), 0);
        chk("g_rst_instr", 64'(instr), 0);
        chk("g_rst_opcode", 64'(opcode), 0);
        chk("g_rst_pc", 64'(instr_pc), 0);
        chk("g_rst_rd_en", 64'(imem_rd_en), 0);
        chk("g_rst_addr", 64'(imem_addr), 0);
        chk("g_rst_halted", 64'(halted), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
